match_event_reporter: RTL and testbench

- Sits directly downstream of the correlator's match/valid outputs.
- Qualifies match pulses and applies a programmable holdoff, so one preamble yields one event.
- Timestamps each accepted event and buffers it in a small FIFO.
- Serialises each event as a two-word record to the inband RX packet builder over a valid/ready handshake.

---
 rtl/match_event_reporter.sv | 181 ++++++++++++++++++
 tb/tb_match_event_reporter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_event_reporter.sv
// match_event_reporter
// Qualifies correlator match pulses, applies a programmable holdoff so one
// preamble yields one event, timestamps accepted events into a small FIFO and
// serialises each event as a two-word record over a valid/ready handshake.
module match_event_reporter #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [7:0]  MARKER = 8'h4D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        match,
    input  logic [31:0] timestamp,
    input  logic        enable,
    input  logic [15:0] holdoff_len,
    input  logic        clear_counts,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] match_count,
    output logic [7:0]  drop_count,
    output logic [15:0] debugbus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = 5;
    localparam int unsigned ENTRY_W = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        TS   = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [15:0]          holdoff_cnt;
    logic [7:0]           seq;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ENTRY_W-1:0]   head;
    logic [31:0]          hdr_word;
    logic [31:0]          ts_word;

    logic qualified;
    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic snapshot;

    assign qualified  = valid & match & enable;
    assign accept     = qualified & (holdoff_cnt == 16'd0);
    assign fifo_full  = (level == LVL_W'(DEPTH));
    assign fifo_empty = (level == LVL_W'(0));
    assign push       = accept & ~fifo_full;
    assign pop        = (state_q == TS) & out_ready;
    assign snapshot   = (state_q == IDLE) & ~fifo_empty;
    assign head       = mem[rd_ptr];

    // Holdoff counter: loaded on an accepted event, forced idle while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdoff_cnt <= 16'd0;
        end else if (!enable) begin
            holdoff_cnt <= 16'd0;
        end else if (accept) begin
            holdoff_cnt <= holdoff_len;
        end else if (holdoff_cnt != 16'd0) begin
            holdoff_cnt <= holdoff_cnt - 16'd1;
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= 16'd0;
            drop_count  <= 8'd0;
        end else begin
            if (clear_counts) begin
                match_count <= 16'd0;
            end else if (qualified && (match_count != 16'hFFFF)) begin
                match_count <= match_count + 16'd1;
            end
            if (clear_counts) begin
                drop_count <= 8'd0;
            end else if (accept && fifo_full && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Event storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {seq, timestamp};
        end
    end

    // FIFO pointers, occupancy and event sequence number
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            seq    <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                seq    <= seq + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Record words captured on entry to HDR so they stay stable while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_word <= 32'd0;
            ts_word  <= 32'd0;
        end else if (snapshot) begin
            hdr_word <= {MARKER, head[39:32], match_count};
            ts_word  <= head[31:0];
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next-state: IDLE -> HDR -> TS -> IDLE, advancing on handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = HDR;
            HDR:     if (out_ready)   state_d = TS;
            TS:      if (out_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output FSM outputs: pure decode of state and captured record words
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'd0;
        case (state_q)
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
            end
            TS: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = ts_word;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign debugbus = {state_q, level, (holdoff_cnt != 16'd0), seq};

endmodule

// File: tb/tb_match_event_reporter.sv
// Self-checking bench for match_event_reporter: scoreboard of {seq, timestamp}
// entries filled as matches are driven, drained as records leave the DUT.
module tb_match_event_reporter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        match;
    logic [31:0] timestamp;
    logic        enable;
    logic [15:0] holdoff_len;
    logic        clear_counts;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] match_count;
    logic [7:0]  drop_count;
    logic [15:0] debugbus;

    match_event_reporter #(.DEPTH(DEPTH), .MARKER(8'h4D)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .match        (match),
        .timestamp    (timestamp),
        .enable       (enable),
        .holdoff_len  (holdoff_len),
        .clear_counts (clear_counts),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .match_count  (match_count),
        .drop_count   (drop_count),
        .debugbus     (debugbus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  seq;
        logic [31:0] ts;
    } entry_t;

    entry_t      sb[$];
    int          passed;
    int          total;
    int          records;
    logic [15:0] m_mc;
    logic [15:0] m_mc_old;
    logic [7:0]  m_dc;
    logic [7:0]  m_seq;
    logic [15:0] m_hold;
    logic [15:0] exp_snap;
    logic        expect_ts;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        rand_ready;

    task automatic model_reset();
        sb.delete();
        m_mc       = 16'd0;
        m_mc_old   = 16'd0;
        m_dc       = 8'd0;
        m_seq      = 8'd0;
        m_hold     = 16'd0;
        exp_snap   = 16'd0;
        expect_ts  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        prev_last  = 1'b0;
    endtask

    // One clock: scoreboard/model update at the negedge, inputs change after posedge
    task automatic tick();
        logic        full_now;
        logic        qual;
        logic        acc;
        logic [31:0] exp_w;
        @(negedge clk);
        if (reset) begin
            model_reset();
        end else begin
            full_now = (sb.size() == DEPTH);
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
                    $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                else
                    passed++;
            end
            if (out_valid && !out_last && !prev_stall) exp_snap = m_mc_old;
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_word: data=%h last=%b required no transfer", out_data, out_last);
                end else if (!expect_ts) begin
                    exp_w = {8'h4D, sb[0].seq, exp_snap};
                    if (out_data !== exp_w || out_last !== 1'b0)
                        $display("FAIL header_word: data=%h last=%b required data=%h last=0",
                                 out_data, out_last, exp_w);
                    else
                        passed++;
                    expect_ts = 1'b1;
                end else begin
                    exp_w = sb[0].ts;
                    if (out_data !== exp_w || out_last !== 1'b1)
                        $display("FAIL ts_word: data=%h last=%b required data=%h last=1",
                                 out_data, out_last, exp_w);
                    else
                        passed++;
                    void'(sb.pop_front());
                    expect_ts = 1'b0;
                    records++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            qual     = valid && match && enable;
            acc      = qual && (m_hold == 16'd0);
            m_mc_old = m_mc;
            if (clear_counts) m_mc = 16'd0;
            else if (qual && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
            if (clear_counts) m_dc = 8'd0;
            else if (acc && full_now && m_dc != 8'hFF) m_dc = m_dc + 8'd1;
            if (acc && !full_now) begin
                sb.push_back({m_seq, timestamp});
                m_seq = m_seq + 8'd1;
            end
            if (!enable) m_hold = 16'd0;
            else if (acc) m_hold = holdoff_len;
            else if (m_hold != 16'd0) m_hold = m_hold - 16'd1;
        end
        @(posedge clk);
        #1;
        timestamp = timestamp + 32'd1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0 || out_valid)
            $display("FAIL drain_timeout: pending=%0d valid=%b required pending=0 valid=0", sb.size(), out_valid);
        else
            passed++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_last, out_data} !== 34'd0)
            $display("FAIL reset_out: valid=%b last=%b data=%h required 0", out_valid, out_last, out_data);
        else passed++;
        total++;
        if (match_count !== 16'd0 || drop_count !== 8'd0)
            $display("FAIL reset_counts: mc=%h dc=%h required 0", match_count, drop_count);
        else passed++;
        total++;
        if (debugbus !== 16'd0)
            $display("FAIL reset_debug: debugbus=%h required 0000", debugbus);
        else passed++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        enable = 1'b1; holdoff_len = 16'd0; out_ready = 1'b1;
        valid = 1'b1; match = 1'b1; timestamp = 32'h100;
        tick();
        valid = 1'b0; match = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL hdr_early: valid=%b required 0", out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h4D000001 || out_last !== 1'b0)
            $display("FAIL hdr_latency: valid=%b data=%h last=%b required 1 4d000001 0", out_valid, out_data, out_last);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000100 || out_last !== 1'b1)
            $display("FAIL ts_latency: valid=%b data=%h last=%b required 1 00000100 1", out_valid, out_data, out_last);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || match_count !== 16'd1)
            $display("FAIL single_end: valid=%b mc=%h required 0 0001", out_valid, match_count);
        else passed++;
    endtask

    task automatic test_holdoff();
        int r0;
        clear_counts = 1'b1; tick(); clear_counts = 1'b0;
        holdoff_len = 16'd10;
        r0 = records;
        valid = 1'b1; match = 1'b1;
        repeat (5) tick();
        valid = 1'b0; match = 1'b0;
        repeat (5) tick();
        total++;
        if (debugbus[8] !== 1'b1) $display("FAIL holdoff_active: bit=%b required 1", debugbus[8]);
        else passed++;
        valid = 1'b1; match = 1'b1;
        repeat (2) tick();
        valid = 1'b0; match = 1'b0;
        drain(100);
        total++;
        if (match_count !== 16'd7) $display("FAIL holdoff_mcount: mc=%0d required 7", match_count);
        else passed++;
        total++;
        if (records - r0 != 2) $display("FAIL holdoff_records: got=%0d required 2", records - r0);
        else passed++;
        holdoff_len = 16'd0;
    endtask

    task automatic test_overflow();
        int r0;
        do_reset();
        holdoff_len = 16'd0; out_ready = 1'b0; enable = 1'b1;
        repeat (6) begin
            valid = 1'b1; match = 1'b1; tick();
            valid = 1'b0; match = 1'b0; tick();
        end
        total++;
        if (drop_count !== 8'd2) $display("FAIL ovf_drops: dc=%0d required 2", drop_count);
        else passed++;
        total++;
        if (debugbus[13:9] !== 5'd4 || debugbus[7:0] !== 8'd4)
            $display("FAIL ovf_level: level=%0d seq=%0d required 4 4", debugbus[13:9], debugbus[7:0]);
        else passed++;
        r0 = records;
        out_ready = 1'b1;
        drain(100);
        total++;
        if (records - r0 != 4) $display("FAIL ovf_records: got=%0d required 4", records - r0);
        else passed++;
    endtask

    task automatic test_random_ready();
        rand_ready = 1'b1;
        repeat (150) begin
            valid       = ($urandom_range(0, 2) == 0);
            match       = ($urandom_range(0, 3) != 0);
            enable      = ($urandom_range(0, 9) != 0);
            holdoff_len = 16'($urandom_range(0, 3));
            tick();
        end
        valid = 1'b0; match = 1'b0; enable = 1'b1;
        drain(2000);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        total++;
        if (match_count !== m_mc || drop_count !== m_dc)
            $display("FAIL rand_counts: mc=%h dc=%h required mc=%h dc=%h", match_count, drop_count, m_mc, m_dc);
        else passed++;
        holdoff_len = 16'd0;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0; holdoff_len = 16'd0; enable = 1'b1;
        valid = 1'b1; match = 1'b1;
        repeat (65540) tick();
        total++;
        if (match_count !== 16'hFFFF || drop_count !== 8'hFF)
            $display("FAIL sat_hold: mc=%h dc=%h required ffff ff", match_count, drop_count);
        else passed++;
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        total++;
        if (match_count !== 16'd0 || drop_count !== 8'd0)
            $display("FAIL clear_priority: mc=%h dc=%h required 0000 00", match_count, drop_count);
        else passed++;
        valid = 1'b0; match = 1'b0;
        do_reset();
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_record();
        int r0;
        do_reset();
        out_ready = 1'b0; holdoff_len = 16'd0; enable = 1'b1;
        valid = 1'b1; match = 1'b1;
        repeat (3) tick();
        valid = 1'b0; match = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || debugbus[13:9] !== 5'd3)
            $display("FAIL in_ts: valid=%b last=%b level=%0d required 1 1 3", out_valid, out_last, debugbus[13:9]);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid: valid=%b required 0", out_valid);
        else passed++;
        total++;
        if (debugbus !== 16'd0) $display("FAIL rst_debug: debugbus=%h required 0000", debugbus);
        else passed++;
        model_reset();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        r0 = records;
        repeat (10) tick();
        total++;
        if (out_valid !== 1'b0 || records != r0)
            $display("FAIL rst_no_records: valid=%b records=%0d required 0 0", out_valid, records - r0);
        else passed++;
    endtask

    initial begin
        passed = 0; total = 0; records = 0; rand_ready = 1'b0;
        reset = 1'b1; valid = 1'b0; match = 1'b0; timestamp = 32'd0;
        enable = 1'b0; holdoff_len = 16'd0; clear_counts = 1'b0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_holdoff();
        test_overflow();
        test_random_ready();
        test_saturation();
        test_reset_mid_record();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
